// File: rtl/pc_ctrl.sv
// pc_ctrl: branch resolution and fetch-PC stage.
// Resolves conditional branches from the comparator flags and computes
// JAL/JALR targets. It owns the fetch PC, squashes younger instructions
// with a fixed-length flush after a redirect, and halts on a misaligned target.
module pc_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_valid_i,
  input  logic        is_branch_i,
  input  logic        is_jal_i,
  input  logic        is_jalr_i,
  input  logic [2:0]  br_op_i,
  input  logic [31:0] pc_ex_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] rs1_data_i,
  input  logic        br_less_i,
  input  logic        br_equal_i,
  input  logic        stall_i,
  input  logic        fetch_ready_i,
  output logic        br_unsigned_o,
  output logic        fetch_req_o,
  output logic [31:0] fetch_addr_o,
  output logic [31:0] link_o,
  output logic        flush_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        taken;
  logic [31:0] target;
  logic        redirect;
  logic        misaligned;
  logic        adv;

  // funct3[1] selects the unsigned flavour (BLTU/BGEU) at the comparator
  assign br_unsigned_o = is_branch_i & br_op_i[1];
  assign link_o        = pc_ex_i + 32'd4;

  // Branch condition decode; 010/011 are not branches and never take
  always_comb begin
    taken = 1'b0;
    case (br_op_i)
      3'b000:  taken = br_equal_i;
      3'b001:  taken = ~br_equal_i;
      3'b100:  taken = br_less_i;
      3'b101:  taken = ~br_less_i;
      3'b110:  taken = br_less_i;
      3'b111:  taken = ~br_less_i;
      default: taken = 1'b0;
    endcase
  end

  // Target select, JALR wins over JAL/branch; JALR clears bit 0
  always_comb begin
    target = pc_ex_i + imm_i;
    if (is_jalr_i) target = (rs1_data_i + imm_i) & ~32'h1;
  end

  assign redirect   = (state == RUN) & instr_valid_i &
                      (is_jal_i | is_jalr_i | (is_branch_i & taken));
  assign misaligned = redirect & (target[1:0] != 2'b00);
  assign adv        = fetch_ready_i & ~stall_i;

  // PC / flush FSM; flush, trap and request flags are registered with the state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= RUN;
      fetch_addr_o <= RESET_PC;
      cnt          <= 4'd0;
      flush_o      <= 1'b0;
      misalign_o   <= 1'b0;
      fetch_req_o  <= 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (misaligned) begin
            // Trap: PC is left where it was
            state       <= HALT;
            misalign_o  <= 1'b1;
            fetch_req_o <= 1'b0;
            flush_o     <= 1'b0;
          end else if (redirect) begin
            // Redirect is not held off by stall or fetch backpressure
            fetch_addr_o <= target;
            cnt          <= 4'(FLUSH_CYCLES - 1);
            state        <= FLUSH;
            flush_o      <= 1'b1;
          end else if (adv) begin
            fetch_addr_o <= fetch_addr_o + 32'd4;
          end
        end
        FLUSH: begin
          // EX inputs are ignored here: the EX instruction is being squashed
          if (adv) fetch_addr_o <= fetch_addr_o + 32'd4;
          if (!stall_i) begin
            if (cnt == 4'd0) begin
              state   <= RUN;
              flush_o <= 1'b0;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
        end
        HALT: begin
          // Only reset leaves the trap
          state <= HALT;
        end
        default: begin
          state       <= HALT;
          misalign_o  <= 1'b1;
          fetch_req_o <= 1'b0;
          flush_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: the expected fetch state is queued when stimulus is
// driven and compared after the following clock edge.
module tb_pc_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_valid_i, is_branch_i, is_jal_i, is_jalr_i;
  logic [2:0]  br_op_i;
  logic [31:0] pc_ex_i, imm_i, rs1_data_i;
  logic        br_less_i, br_equal_i, stall_i, fetch_ready_i;
  logic        br_unsigned_o, fetch_req_o, flush_o, misalign_o;
  logic [31:0] fetch_addr_o, link_o;

  pc_ctrl #(.RESET_PC(32'h0), .FLUSH_CYCLES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_valid_i(instr_valid_i),
    .is_branch_i(is_branch_i), .is_jal_i(is_jal_i), .is_jalr_i(is_jalr_i),
    .br_op_i(br_op_i), .pc_ex_i(pc_ex_i), .imm_i(imm_i), .rs1_data_i(rs1_data_i),
    .br_less_i(br_less_i), .br_equal_i(br_equal_i), .stall_i(stall_i),
    .fetch_ready_i(fetch_ready_i), .br_unsigned_o(br_unsigned_o),
    .fetch_req_o(fetch_req_o), .fetch_addr_o(fetch_addr_o), .link_o(link_o),
    .flush_o(flush_o), .misalign_o(misalign_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        fl;
    logic        mis;
    logic        req;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic [31:0] epc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    instr_valid_i = 0; is_branch_i = 0; is_jal_i = 0; is_jalr_i = 0;
    br_op_i = 3'b000; pc_ex_i = 0; imm_i = 0; rs1_data_i = 0;
    br_less_i = 0; br_equal_i = 0; stall_i = 0; fetch_ready_i = 1;
  endtask

  // queue expectation for the coming edge, then compare after it
  task automatic step_full(input string tag, input logic [31:0] a, input logic fl,
                           input logic mis, input logic req);
    exp_t e, o;
    e.addr = a; e.fl = fl; e.mis = mis; e.req = req;
    sb.push_back(e);
    @(posedge clk_i); #1;
    o = sb.pop_front();
    chk({tag, ".addr"}, fetch_addr_o, o.addr);
    chk({tag, ".flush"}, {31'b0, flush_o}, {31'b0, o.fl});
    chk({tag, ".mis"}, {31'b0, misalign_o}, {31'b0, o.mis});
    chk({tag, ".req"}, {31'b0, fetch_req_o}, {31'b0, o.req});
  endtask

  task automatic step(input string tag, input logic [31:0] a, input logic fl);
    step_full(tag, a, fl, 1'b0, 1'b1);
  endtask

  function automatic logic exp_taken(input logic [2:0] op, input logic l, input logic e);
    case (op)
      3'b000: return e;
      3'b001: return !e;
      3'b100, 3'b110: return l;
      3'b101, 3'b111: return !l;
      default: return 1'b0;
    endcase
  endfunction

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [2:0] ops [8];
    logic [1:0] lc  [3];
    logic       t;
    ops = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};
    lc  = '{2'b10, 2'b01, 2'b00};

    idle();
    rst_i = 1;
    #12;
    chk("rst.addr", fetch_addr_o, 32'h0);
    chk("rst.flush", {31'b0, flush_o}, 32'h0);
    chk("rst.mis", {31'b0, misalign_o}, 32'h0);
    chk("rst.req", {31'b0, fetch_req_o}, 32'h1);
    @(posedge clk_i); #1;
    rst_i = 0;

    // Sequential fetch and stall hold
    step("seq", 32'h4, 0);
    step("seq", 32'h8, 0);
    step("seq", 32'hC, 0);
    stall_i = 1;
    step("stall", 32'hC, 0);
    step("stall", 32'hC, 0);
    stall_i = 0;

    // BLTU taken: flush exactly two cycles
    instr_valid_i = 1; is_branch_i = 1; br_op_i = 3'b110;
    pc_ex_i = 32'h100; imm_i = 32'h40; br_less_i = 1;
    #1;
    chk("bltu.uns", {31'b0, br_unsigned_o}, 32'h1);
    chk("bltu.link", link_o, 32'h104);
    step("bltu.t", 32'h140, 1);
    idle();
    step("bltu.f1", 32'h144, 1);
    step("bltu.f2", 32'h148, 0);
    // BLTU not taken
    instr_valid_i = 1; is_branch_i = 1; br_op_i = 3'b110;
    pc_ex_i = 32'h100; imm_i = 32'h40; br_less_i = 0;
    step("bltu.nt", 32'h14C, 0);
    idle();
    epc = 32'h14C;

    // funct3 x {less, equal, neither} matrix
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 3; j++) begin
        instr_valid_i = 1; is_branch_i = 1; br_op_i = ops[i];
        pc_ex_i = 32'h200; imm_i = 32'h20;
        br_less_i = lc[j][1]; br_equal_i = lc[j][0];
        #1;
        chk("mtx.uns", {31'b0, br_unsigned_o}, {31'b0, ops[i][1]});
        t = exp_taken(ops[i], lc[j][1], lc[j][0]);
        if (t) begin
          epc = 32'h220;
          step("mtx.t", epc, 1);
          idle();
          epc = epc + 4; step("mtx.f1", epc, 1);
          epc = epc + 4; step("mtx.f2", epc, 0);
        end else begin
          epc = epc + 4;
          step("mtx.nt", epc, 0);
          idle();
        end
      end
    end

    // JAL, taken branch during flush ignored, stall extends flush
    instr_valid_i = 1; is_jal_i = 1; pc_ex_i = 32'h300; imm_i = 32'h100;
    step("jal", 32'h400, 1);
    idle();
    instr_valid_i = 1; is_branch_i = 1; br_op_i = 3'b000; br_equal_i = 1;
    pc_ex_i = 32'h500; imm_i = 32'h10;
    step("nest", 32'h404, 1);
    idle();
    stall_i = 1;
    step("fstall", 32'h404, 1);
    stall_i = 0;
    step("fend", 32'h408, 0);

    // Redirect wins over stall and backpressure
    instr_valid_i = 1; is_jal_i = 1; pc_ex_i = 32'h600; imm_i = 32'h8;
    stall_i = 1; fetch_ready_i = 0;
    step("jalstall", 32'h608, 1);
    idle();
    step("jalstall.f1", 32'h60C, 1);
    step("jalstall.f2", 32'h610, 0);

    // JALR has priority over JAL; bit 0 cleared
    instr_valid_i = 1; is_jal_i = 1; is_jalr_i = 1;
    pc_ex_i = 32'h0; imm_i = 32'h11; rs1_data_i = 32'h1000;
    step("prio", 32'h1010, 1);
    idle();
    step("prio.f1", 32'h1014, 1);
    step("prio.f2", 32'h1018, 0);

    // PC wrap and link wrap
    pc_ex_i = 32'hFFFF_FFFC;
    #1;
    chk("link.wrap", link_o, 32'h0);
    instr_valid_i = 1; is_jal_i = 1; pc_ex_i = 32'h0; imm_i = 32'hFFFF_FFF4;
    step("wrap.j", 32'hFFFF_FFF4, 1);
    idle();
    step("wrap.f1", 32'hFFFF_FFF8, 1);
    step("wrap.f2", 32'hFFFF_FFFC, 0);
    step("wrap", 32'h0, 0);

    // Async reset in the middle of a flush
    instr_valid_i = 1; is_jal_i = 1; pc_ex_i = 32'h40; imm_i = 32'h40;
    step("rf.j", 32'h80, 1);
    idle();
    #2; rst_i = 1; #1;
    chk("rf.addr", fetch_addr_o, 32'h0);
    chk("rf.flush", {31'b0, flush_o}, 32'h0);
    @(posedge clk_i); #1;
    rst_i = 0;
    step("rf.run", 32'h4, 0);

    // Misaligned JALR traps and freezes
    instr_valid_i = 1; is_jalr_i = 1; rs1_data_i = 32'h2003; imm_i = 32'h4;
    step_full("mis", 32'h4, 0, 1, 0);
    idle();
    step_full("halt", 32'h4, 0, 1, 0);
    instr_valid_i = 1; is_jal_i = 1; pc_ex_i = 32'h0; imm_i = 32'h100;
    step_full("halt.j", 32'h4, 0, 1, 0);
    idle();
    #2; rst_i = 1; #1;
    chk("hrst.addr", fetch_addr_o, 32'h0);
    chk("hrst.mis", {31'b0, misalign_o}, 32'h0);
    chk("hrst.req", {31'b0, fetch_req_o}, 32'h1);
    @(posedge clk_i); #1;
    rst_i = 0;
    step("post", 32'h4, 0);

    chk("sb.empty", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
